// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board size defaults, sequencer states, winner codes.
package connect4_pkg;
  localparam int C4_COLS = 7;
  localparam int C4_ROWS = 6;

  typedef enum logic [1:0] {IDLE = 2'd0, PLACE = 2'd1, CHECK = 2'd2, OVER = 2'd3} mc_state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic [1:0] winner_of(input logic player);
    return player ? WIN_B : WIN_A;
  endfunction
endpackage

// File: rtl/move_controller_if.sv
// Player-input, board-write and win-check signals of the move controller.
interface move_controller_if
  import connect4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS
);
  logic                      left_pulse, right_pulse, put_pulse, new_game;
  logic [$clog2(COLS)-1:0]   cursor_col;
  logic                      turn;
  logic                      wr_en;
  logic [$clog2(ROWS)-1:0]   wr_row;
  logic [$clog2(COLS)-1:0]   wr_col;
  logic                      wr_player;
  logic                      chk_req, chk_done, chk_win;
  logic                      game_over;
  logic [1:0]                winner;

  modport master (
    input  left_pulse, right_pulse, put_pulse, new_game, chk_done, chk_win,
    output cursor_col, turn, wr_en, wr_row, wr_col, wr_player, chk_req, game_over, winner
  );
  modport slave (
    output left_pulse, right_pulse, put_pulse, new_game, chk_done, chk_win,
    input  cursor_col, turn, wr_en, wr_row, wr_col, wr_player, chk_req, game_over, winner
  );
endinterface

// File: rtl/column_heights.sv
// Per-column fill counters: one counter per column, read by column, full flags.
module column_heights
  import connect4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       inc_i,
  input  logic [$clog2(COLS)-1:0]    inc_col_i,
  input  logic [$clog2(COLS)-1:0]    rd_col_i,
  output logic [$clog2(ROWS+1)-1:0]  rd_height_o,
  output logic [COLS-1:0]            full_o
);
  localparam int CW = $clog2(COLS);
  localparam int HW = $clog2(ROWS+1);

  logic [COLS-1:0][HW-1:0] h_all;

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [HW-1:0] h_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                            h_q <= '0;
      else if (clr_i)                                        h_q <= '0;
      else if (inc_i && inc_col_i == CW'(c) && !full_o[c])   h_q <= h_q + 1'b1;
    end
    assign h_all[c]  = h_q;
    assign full_o[c] = (h_q == HW'(ROWS));
  end

  assign rd_height_o = h_all[rd_col_i];
endmodule

// File: rtl/move_controller.sv
// Connect-4 turn-and-move sequencer: cursor, drop, win-check handshake, game end.
// Build option: define CURSOR_WRAP_EN to make the cursor wrap at the board edges.
module move_controller
  import connect4_pkg::*;
#(
  parameter int COLS = C4_COLS,
  parameter int ROWS = C4_ROWS
) (
  input  logic               clk,
  input  logic               rst,
  move_controller_if.master  bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int HW = $clog2(ROWS+1);
  localparam int MW = $clog2(ROWS*COLS+1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS-1);
  localparam logic [CW-1:0] COL_MID = CW'(COLS/2);
  localparam logic [MW-1:0] CELLS   = MW'(ROWS*COLS);

  mc_state_e      state_q, state_d;
  logic [CW-1:0]  cursor_q, cursor_d;
  logic           turn_q, turn_d;
  logic [MW-1:0]  moves_q, moves_d;
  logic           wr_en_q, wr_en_d;
  logic [RW-1:0]  wr_row_q, wr_row_d;
  logic [CW-1:0]  wr_col_q, wr_col_d;
  logic           wr_player_q, wr_player_d;
  logic           chk_req_q, chk_req_d;
  logic           game_over_q, game_over_d;
  logic [1:0]     winner_q, winner_d;

  logic [HW-1:0]   cur_height;
  logic [COLS-1:0] full;
  logic            inc, clr;

  // wr_col_q doubles as the latched drop column for the PLACE increment
  column_heights #(.COLS(COLS), .ROWS(ROWS)) u_heights (
    .clk         (clk),
    .rst_n       (rst),
    .clr_i       (clr),
    .inc_i       (inc),
    .inc_col_i   (wr_col_q),
    .rd_col_i    (cursor_q),
    .rd_height_o (cur_height),
    .full_o      (full)
  );

  always_comb begin
    state_d     = state_q;
    cursor_d    = cursor_q;
    turn_d      = turn_q;
    moves_d     = moves_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_player_d = wr_player_q;
    chk_req_d   = chk_req_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    inc         = 1'b0;
    clr         = 1'b0;
    if (bus.new_game) begin
      state_d     = IDLE;
      cursor_d    = COL_MID;
      turn_d      = 1'b0;
      moves_d     = '0;
      chk_req_d   = 1'b0;
      game_over_d = 1'b0;
      winner_d    = WIN_NONE;
      clr         = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.put_pulse) begin
            if (!full[cursor_q]) begin
              state_d     = PLACE;
              wr_en_d     = 1'b1;
              wr_row_d    = RW'(cur_height);
              wr_col_d    = cursor_q;
              wr_player_d = turn_q;
            end
          end else if (bus.left_pulse && !bus.right_pulse) begin
`ifdef CURSOR_WRAP_EN
            cursor_d = (cursor_q == '0) ? COL_MAX : cursor_q - 1'b1;
`else
            if (cursor_q != '0) cursor_d = cursor_q - 1'b1;
`endif
          end else if (bus.right_pulse && !bus.left_pulse) begin
`ifdef CURSOR_WRAP_EN
            cursor_d = (cursor_q == COL_MAX) ? '0 : cursor_q + 1'b1;
`else
            if (cursor_q != COL_MAX) cursor_d = cursor_q + 1'b1;
`endif
          end
        end
        PLACE: begin
          inc       = 1'b1;
          moves_d   = moves_q + 1'b1;
          chk_req_d = 1'b1;
          state_d   = CHECK;
        end
        CHECK: begin
          if (bus.chk_done) begin
            chk_req_d = 1'b0;
            if (bus.chk_win) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = winner_of(turn_q);
            end else if (moves_q == CELLS) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = WIN_DRAW;
            end else begin
              turn_d  = ~turn_q;
              state_d = IDLE;
            end
          end
        end
        OVER: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cursor_q    <= COL_MID;
      turn_q      <= 1'b0;
      moves_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_player_q <= 1'b0;
      chk_req_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      turn_q      <= turn_d;
      moves_q     <= moves_d;
      wr_en_q     <= wr_en_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_player_q <= wr_player_d;
      chk_req_q   <= chk_req_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
    end
  end

  assign bus.cursor_col = cursor_q;
  assign bus.turn       = turn_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_row     = wr_row_q;
  assign bus.wr_col     = wr_col_q;
  assign bus.wr_player  = wr_player_q;
  assign bus.chk_req    = chk_req_q;
  assign bus.game_over  = game_over_q;
  assign bus.winner     = winner_q;
endmodule

// File: tb/tb_move_controller.sv
// Bench for move_controller: directed game scenarios plus random play against a board model.
module tb_move_controller;
  localparam int COLS = 7;
  localparam int ROWS = 6;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  move_controller_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  move_controller #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // board model: column heights, cursor, whose turn, moves, end state
  int m_h[COLS];
  int m_cur, m_turn, m_moves, m_over, m_win;

  task automatic model_reset();
    for (int c = 0; c < COLS; c++) m_h[c] = 0;
    m_cur = COLS / 2; m_turn = 0; m_moves = 0; m_over = 0; m_win = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".cursor"}, 32'(bus.cursor_col), 32'(m_cur));
    chk({tag, ".turn"}, 32'(bus.turn), 32'(m_turn));
    chk({tag, ".over"}, 32'(bus.game_over), 32'(m_over));
    chk({tag, ".winner"}, 32'(bus.winner), 32'(m_win));
  endtask

  task automatic move(input bit l, input bit r);
    @(negedge clk) begin bus.left_pulse = l; bus.right_pulse = r; end
    @(negedge clk) begin bus.left_pulse = 1'b0; bus.right_pulse = 1'b0; end
    if (!m_over && l != r) begin
      if (l) m_cur = (m_cur == 0) ? (WRAP ? COLS - 1 : 0) : m_cur - 1;
      else   m_cur = (m_cur == COLS - 1) ? (WRAP ? 0 : COLS - 1) : m_cur + 1;
    end
    chk("cursor", 32'(bus.cursor_col), 32'(m_cur));
  endtask

  task automatic do_put(input bit win, input int dly);
    bit legal;
    legal = !m_over && (m_h[m_cur] < ROWS);
    @(negedge clk) bus.put_pulse = 1'b1;
    @(negedge clk) bus.put_pulse = 1'b0;
    if (!legal) begin
      chk("no_wr_en", 32'(bus.wr_en), 0);
      @(negedge clk);
      chk("no_chk_req", 32'(bus.chk_req), 0);
      chk_state("ignored_put");
      return;
    end
    chk("wr_en", 32'(bus.wr_en), 1);
    chk("wr_row", 32'(bus.wr_row), 32'(m_h[m_cur]));
    chk("wr_col", 32'(bus.wr_col), 32'(m_cur));
    chk("wr_player", 32'(bus.wr_player), 32'(m_turn));
    m_h[m_cur]++;
    m_moves++;
    @(negedge clk);
    chk("wr_en_pulse", 32'(bus.wr_en), 0);
    chk("chk_req_rise", 32'(bus.chk_req), 1);
    repeat (dly) @(negedge clk);
    if (dly > 0) chk("chk_req_hold", 32'(bus.chk_req), 1);
    bus.chk_done = 1'b1; bus.chk_win = win;
    @(negedge clk) begin bus.chk_done = 1'b0; bus.chk_win = 1'b0; end
    if (win) begin m_over = 1; m_win = m_turn ? 2 : 1; end
    else if (m_moves == ROWS * COLS) begin m_over = 1; m_win = 3; end
    else m_turn ^= 1;
    chk("chk_req_drop", 32'(bus.chk_req), 0);
    chk_state("after_check");
  endtask

  task automatic new_game();
    @(negedge clk) bus.new_game = 1'b1;
    @(negedge clk) bus.new_game = 1'b0;
    model_reset();
    chk_state("new_game");
    chk("ng_chk_req", 32'(bus.chk_req), 0);
  endtask

  initial begin
    bus.left_pulse = 0; bus.right_pulse = 0; bus.put_pulse = 0;
    bus.new_game = 0; bus.chk_done = 0; bus.chk_win = 0;
    model_reset();

    // reset values
    @(negedge clk);
    chk_state("reset");
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_row", 32'(bus.wr_row), 0);
    chk("rst_wr_col", 32'(bus.wr_col), 0);
    chk("rst_wr_player", 32'(bus.wr_player), 0);
    chk("rst_chk_req", 32'(bus.chk_req), 0);
    @(negedge clk) rst_n = 1'b1;

    // three drops on the middle column, alternating players
    for (int i = 0; i < 3; i++) do_put(1'b0, i);

    // seven drops on column 0: the seventh finds the column full
    repeat (3) move(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) do_put(1'b0, $urandom_range(0, 2));
    move(1'b0, 1'b1);

    // edge behaviour and simultaneous left/right
    new_game();
    repeat (4) move(1'b1, 1'b0);
    chk("edge_cursor", 32'(bus.cursor_col), WRAP ? 32'd6 : 32'd0);
    move(1'b1, 1'b1);
    move(1'b0, 1'b1);
    move(1'b1, 1'b1);

    // player B wins; further drops ignored until restart
    new_game();
    do_put(1'b0, 0);
    move(1'b0, 1'b1);
    do_put(1'b1, 1);
    chk("b_wins", 32'(bus.winner), 32'd2);
    do_put(1'b0, 0);
    move(1'b1, 1'b0);
    new_game();

    // full board, no winner: draw
    repeat (3) move(1'b1, 1'b0);
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) do_put(1'b0, $urandom_range(0, 3));
      if (c < COLS - 1) move(1'b0, 1'b1);
    end
    chk("draw_winner", 32'(bus.winner), 32'd3);
    chk("draw_over", 32'(bus.game_over), 32'd1);

    // restart while a check is pending
    new_game();
    @(negedge clk) bus.put_pulse = 1'b1;
    @(negedge clk) bus.put_pulse = 1'b0;
    @(negedge clk);
    chk("pend_chk_req", 32'(bus.chk_req), 1);
    bus.new_game = 1'b1;
    @(negedge clk) bus.new_game = 1'b0;
    chk("ng_drops_chk_req", 32'(bus.chk_req), 0);
    model_reset();
    chk_state("ng_in_check");
    do_put(1'b0, 0);
    move(1'b1, 1'b0);
    do_put(1'b0, 0);

    // random play
    new_game();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 19))
        0:              new_game();
        1, 2, 3, 4:     move(1'b1, 1'b0);
        5, 6, 7, 8:     move(1'b0, 1'b1);
        9:              move(1'b1, 1'b1);
        default:        do_put($urandom_range(0, 24) == 0, $urandom_range(0, 3));
      endcase
    end

    // asynchronous reset in the middle of a check
    new_game();
    @(negedge clk) bus.put_pulse = 1'b1;
    @(negedge clk) bus.put_pulse = 1'b0;
    @(negedge clk);
    chk("pre_rst_chk_req", 32'(bus.chk_req), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_chk_req", 32'(bus.chk_req), 0);
    model_reset();
    chk_state("async_rst");
    @(negedge clk) rst_n = 1'b1;
    do_put(1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/move_controller.md
# move_controller

Turn-and-move sequencer for the Connect-4 game. It consumes the single-cycle, debounced `left_pulse`/`right_pulse`/`put_pulse` strobes from the input-conditioning stage, keeps the cursor column, the per-column fill heights, the move count and the player turn. On a legal drop it issues one board write, then handshakes with the win checker to decide whether the game continues, is won or is drawn.

## Interface
Parameters:
- `COLS`, 7: board columns.
- `ROWS`, 6: board rows; row 0 is the bottom.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `left_pulse` in 1: one-cycle move-left strobe.
- `right_pulse` in 1: one-cycle move-right strobe.
- `put_pulse` in 1: one-cycle drop strobe.
- `new_game` in 1: one-cycle restart strobe.
- `cursor_col` out $clog2(COLS): current cursor column.
- `turn` out 1: player to move; 0 = A, 1 = B.
- `wr_en` out 1: board write strobe, one cycle.
- `wr_row` out $clog2(ROWS): row of the write.
- `wr_col` out $clog2(COLS): column of the write.
- `wr_player` out 1: owner of the written cell.
- `chk_req` out 1: win-check request, level.
- `chk_done` in 1: win-check completion, one cycle.
- `chk_win` in 1: win result; valid only with `chk_done`.
- `game_over` out 1: game finished.
- `winner` out 2: 00 none, 01 A, 10 B, 11 draw.

## Operation
- States: IDLE, PLACE, CHECK, OVER.
- **IDLE:**
  - `put_pulse` with `height[cursor_col] < ROWS` goes to PLACE and latches the column.
  - `put_pulse` on a full column is ignored; the state stays IDLE.
  - `left_pulse` alone decrements the cursor; `right_pulse` alone increments it.
  - `left_pulse` and `right_pulse` together cause no cursor change.
  - `put_pulse` has priority over left/right in the same cycle; the cursor is unchanged.
- **PLACE:**
  - Assert `wr_en` for exactly one cycle with `wr_row = height[col]`, `wr_col = col`, `wr_player = turn`.
  - Increment `height[col]` and the move count.
  - Go to CHECK.
- **CHECK:**
  - Hold `chk_req` high until `chk_done`.
  - `chk_win = 1` goes to OVER with `winner = turn ? 10 : 01`.
  - Otherwise, if the move count equals `ROWS*COLS`, go to OVER with `winner = 11`.
  - Otherwise toggle `turn` and return to IDLE.
  - `chk_done` in the same cycle `chk_req` first rises is legal.
- **OVER:**
  - `game_over = 1`.
  - All pulses are ignored.
- **`new_game` (any state, highest priority):** next cycle, clear heights, move count, `winner`, `turn = 0`, `cursor_col = COLS/2`, state IDLE.
- Pulses arriving outside IDLE are dropped, not queued.
- Move counter width is $clog2(ROWS*COLS+1); heights are $clog2(ROWS+1) wide each.

## Timing
- **Reset values:**
  - `cursor_col = COLS/2` (3).
  - `turn = 0`.
  - `wr_en = 0`, `wr_row = 0`, `wr_col = 0`, `wr_player = 0`.
  - `chk_req = 0`, `game_over = 0`, `winner = 00`.
  - State IDLE; heights and move count 0.
- All outputs are registered.
- `put_pulse` at cycle N gives `wr_en` at N+1 and `chk_req` rising at N+2.
- With `chk_done` at cycle M, `turn` or `game_over` updates at M+1, and IDLE accepts input at M+1.
- A cursor pulse at cycle N is visible on `cursor_col` at N+1.
- A reset assertion mid-CHECK drops `chk_req` immediately (asynchronous); the board contents are the board owner's responsibility.

## Configuration
- Macro `CURSOR_WRAP_EN`.
- **Defined:** left at column 0 goes to `COLS-1`; right at `COLS-1` goes to 0.
- **Undefined:** the cursor saturates at 0 and `COLS-1`; pulses at the edge are no-ops.

## Structure
- Package `connect4_pkg` holds:
  - the state enum (IDLE/PLACE/CHECK/OVER);
  - the `winner` encoding constants;
  - default `COLS`/`ROWS` localparams, shared with the win checker and display.
- One sub-module, `column_heights`:
  - COLS counters with a read by column, an increment strobe, a clear, and a per-column full flag.

## Test plan
- After reset: `cursor_col = 3`, `turn = 0`. Three `put_pulse` (with `chk_done` and `chk_win = 0` each) give `wr_row` 0, 1, 2 on column 3, `wr_player` 0, 1, 0.
- Seven `put_pulse` on column 0: six writes (rows 0–5); the seventh produces no `wr_en` and the state stays IDLE.
- `left_pulse` ×4 from column 3: with `CURSOR_WRAP_EN` gives `cursor_col = 6`; without it gives 0. `left_pulse` and `right_pulse` in the same cycle leave the cursor unchanged.
- `chk_done` with `chk_win = 1` after a player-B drop gives `game_over = 1` and `winner = 10`. Later `put_pulse` gives no `wr_en`; `new_game` returns to IDLE with `turn = 0`.
- Fill all 42 cells with `chk_win = 0`: after the 42nd check, `winner = 11` and `game_over = 1`.
- `new_game` during CHECK while `chk_req` is high: `chk_req` drops next cycle and all heights read 0.
